// File: rtl/exec_backend_pipe.sv
// EX/MEM/WB back-end: register file, operand forwarding, load-use interlock, req/ack data memory.
// FWD_PATHS_EN enables the MEM/WB forwarding paths; without it EX stalls on any in-flight producer.
module exec_backend_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [RAW-1:0]  iss_rs1,
  input  logic [RAW-1:0]  iss_rs2,
  input  logic [RAW-1:0]  iss_rd,
  input  logic [XLEN-1:0] iss_imm,
  input  logic [2:0]      iss_aluop,
  input  logic            iss_alusrc,
  input  logic            iss_memrd,
  input  logic            iss_memwr,
  input  logic            iss_regwr,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [RAW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7
  } aluop_t;

  logic [XLEN-1:0] regs [NREGS];

  logic            ex_valid, ex_alusrc, ex_load, ex_store, ex_regwr;
  logic [RAW-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_imm;
  aluop_t          ex_aluop;

  logic            mem_valid, mem_regwr, mem_load, mem_store;
  logic [RAW-1:0]  mem_rd;
  logic [XLEN-1:0] mem_res, mem_wdata;

  logic [XLEN-1:0] op_a, op_b, rs2_val, alu_res;
  logic            use_rs2, hazard, mem_busy, ex_adv, accept, wb_next;

  assign use_rs2 = !ex_alusrc || ex_store;

  always_comb begin
    op_a    = (ex_rs1 == '0) ? '0 : regs[ex_rs1];
    rs2_val = (ex_rs2 == '0) ? '0 : regs[ex_rs2];
`ifdef FWD_PATHS_EN
    // Youngest producer wins: MEM ALU result, then the WB value about to be written.
    if (ex_rs1 != '0) begin
      if (mem_valid && mem_regwr && !mem_load && mem_rd == ex_rs1) op_a = mem_res;
      else if (wb_valid && wb_rd == ex_rs1)                        op_a = wb_data;
    end
    if (ex_rs2 != '0) begin
      if (mem_valid && mem_regwr && !mem_load && mem_rd == ex_rs2) rs2_val = mem_res;
      else if (wb_valid && wb_rd == ex_rs2)                        rs2_val = wb_data;
    end
    hazard = mem_valid && mem_load && mem_regwr && mem_rd != '0 &&
             (mem_rd == ex_rs1 || (use_rs2 && mem_rd == ex_rs2));
`else
    hazard = (mem_valid && mem_regwr && mem_rd != '0 &&
              (mem_rd == ex_rs1 || (use_rs2 && mem_rd == ex_rs2))) ||
             (wb_valid && (wb_rd == ex_rs1 || (use_rs2 && wb_rd == ex_rs2)));
`endif
  end

  assign op_b = ex_alusrc ? ex_imm : rs2_val;

  always_comb begin
    alu_res = '0;
    case (ex_aluop)
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLL: alu_res = op_a << op_b[SHW-1:0];
      OP_SRL: alu_res = op_a >> op_b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  assign mem_busy  = mem_valid && (mem_load || mem_store) && !dmem_ack;
  assign ex_adv    = ex_valid && !mem_busy && !hazard && !flush;
  assign iss_ready = !ex_valid || ex_adv;
  assign accept    = iss_valid && iss_ready && !flush;
  assign wb_next   = mem_valid && !mem_busy && mem_regwr && mem_rd != '0;

  assign dmem_req   = mem_valid && (mem_load || mem_store);
  assign dmem_we    = mem_valid && mem_store;
  assign dmem_addr  = mem_res;
  assign dmem_wdata = mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_imm    <= '0;
      ex_aluop  <= OP_ADD;
      ex_alusrc <= 1'b0;
      ex_load   <= 1'b0;
      ex_store  <= 1'b0;
      ex_regwr  <= 1'b0;
      mem_valid <= 1'b0;
      mem_regwr <= 1'b0;
      mem_load  <= 1'b0;
      mem_store <= 1'b0;
      mem_rd    <= '0;
      mem_res   <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid  <= 1'b1;
        ex_rs1    <= iss_rs1;
        ex_rs2    <= iss_rs2;
        ex_rd     <= iss_rd;
        ex_imm    <= iss_imm;
        ex_aluop  <= aluop_t'(iss_aluop);
        ex_alusrc <= iss_alusrc;
        ex_load   <= iss_memrd;
        ex_store  <= iss_memwr && !iss_memrd;
        ex_regwr  <= iss_regwr;
      end else if (ex_adv) begin
        ex_valid <= 1'b0;
      end

      // A stalled EX leaves a bubble in MEM; a waiting memory op freezes MEM.
      if (!mem_busy) begin
        mem_valid <= ex_adv;
        if (ex_adv) begin
          mem_rd    <= ex_rd;
          mem_regwr <= ex_regwr;
          mem_load  <= ex_load;
          mem_store <= ex_store;
          mem_res   <= alu_res;
          mem_wdata <= rs2_val;
        end
      end

      wb_valid <= wb_next;
      if (wb_next) begin
        wb_rd   <= mem_rd;
        wb_data <= mem_load ? dmem_rdata : mem_res;
      end

      if (wb_valid) regs[wb_rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_exec_backend_pipe.sv
// Directed bench for exec_backend_pipe: architectural model predicts retirements and memory requests.
module tb_exec_backend_pipe;
  localparam int XLEN = 32, NREGS = 32, RAW = 5;
`ifdef FWD_PATHS_EN
  localparam int GAP1 = 1, WAIT2 = 5 - 1;
`else
  localparam int GAP1 = 3, WAIT2 = 5;
`endif

  logic clk = 0, rst = 1;
  logic iss_valid = 0, iss_ready;
  logic [RAW-1:0] iss_rs1 = 0, iss_rs2 = 0, iss_rd = 0;
  logic [XLEN-1:0] iss_imm = 0;
  logic [2:0] iss_aluop = 0;
  logic iss_alusrc = 0, iss_memrd = 0, iss_memwr = 0, iss_regwr = 0, flush = 0;
  logic dmem_req, dmem_we, dmem_ack = 0;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic wb_valid;
  logic [RAW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  exec_backend_pipe #(.XLEN(XLEN), .NREGS(NREGS), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_imm(iss_imm),
    .iss_aluop(iss_aluop), .iss_alusrc(iss_alusrc), .iss_memrd(iss_memrd),
    .iss_memwr(iss_memwr), .iss_regwr(iss_regwr), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural model
  typedef struct { int rd; logic [31:0] data; } ret_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  ret_t exp_q[$];
  req_t req_q[$];
  logic [31:0] mregs [NREGS];
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] ram  [logic [31:0]];

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic model_accept(input logic [2:0] op, input int rd, rs1, rs2, input logic [31:0] imm,
                              input bit src, rd_m, wr_m, rw);
    logic [31:0] a, b, r, v;
    a = mregs[rs1];
    b = src ? imm : mregs[rs2];
    r = alu(op, a, b);
    v = r;
    if (rd_m) begin
      v = mmem.exists(r) ? mmem[r] : 32'd0;
      req_q.push_back('{0, r, 32'd0});
    end else if (wr_m) begin
      req_q.push_back('{1, r, mregs[rs2]});
      mmem[r] = mregs[rs2];
    end
    if (rw && rd != 0) begin
      exp_q.push_back('{rd, v});
      mregs[rd] = v;
    end
  endtask

  // Memory responder: ack in the lat-th cycle of a request
  int lat = 1, rcnt = 0;
  always @(negedge clk) begin
    if (dmem_ack) rcnt = 0;
    dmem_ack = 0;
    if (dmem_req) begin
      rcnt++;
      if (rcnt >= lat) begin
        dmem_ack = 1;
        if (dmem_we) ram[dmem_addr] = dmem_wdata;
        else dmem_rdata = ram.exists(dmem_addr) ? ram[dmem_addr] : 32'd0;
      end
    end else rcnt = 0;
  end

  // Compare process
  logic [31:0] log_data [NREGS];
  bit log_valid [NREGS];
  int wb_cyc [NREGS];
  int wb_count = 0, req_len = 0, last_req_len = 0;
  bit last_we = 0;
  logic [31:0] last_wdata = 0;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) check("unexpected wb", {27'd0, wb_rd}, 32'hFFFFFFFF);
        else begin
          check("wb_rd", {27'd0, wb_rd}, exp_q[0].rd);
          check("wb_data", wb_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        log_data[wb_rd] = wb_data;
        log_valid[wb_rd] = 1;
        wb_cyc[wb_rd] = cyc;
        wb_count++;
      end
      if (dmem_req) begin
        if (req_q.size() == 0) check("unexpected req", dmem_addr, 32'hFFFFFFFF);
        else begin
          check("dmem_we", {31'd0, dmem_we}, {31'd0, req_q[0].we});
          check("dmem_addr", dmem_addr, req_q[0].addr);
          if (req_q[0].we) check("dmem_wdata", dmem_wdata, req_q[0].wdata);
        end
        req_len++;
        if (dmem_ack) begin
          last_req_len = req_len;
          last_we = dmem_we;
          last_wdata = dmem_wdata;
          req_len = 0;
          if (req_q.size() != 0) void'(req_q.pop_front());
        end
      end
    end
  end

  // Stimulus helpers; each starts and ends just after a negedge
  int last_acc = 0;
  task automatic issue(input logic [2:0] op, input int rd, rs1, rs2, input logic [31:0] imm,
                       input bit src, rd_m, wr_m, rw, push, output int waits);
    waits = 0;
    iss_valid = 1; iss_aluop = op; iss_rd = RAW'(rd); iss_rs1 = RAW'(rs1); iss_rs2 = RAW'(rs2);
    iss_imm = imm; iss_alusrc = src; iss_memrd = rd_m; iss_memwr = wr_m; iss_regwr = rw;
    forever begin
      #1;
      if (iss_ready) break;
      @(negedge clk);
      waits++;
      if (waits > 300) begin
        check("issue timeout", 32'd0, 32'd1);
        iss_valid = 0;
        return;
      end
    end
    @(posedge clk);
    if (push) model_accept(op, rd, rs1, rs2, imm, src, rd_m, wr_m, rw);
    @(negedge clk);
    iss_valid = 0;
    last_acc = cyc;
  endtask

  task automatic alu_op(input logic [2:0] op, input int rd, rs1, rs2, input logic [31:0] imm, input bit src);
    int w;
    issue(op, rd, rs1, rs2, imm, src, 0, 0, 1, 1, w);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'd0, n >= 300}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  typedef struct { logic [2:0] op; int rd, rs1, rs2; logic [31:0] imm; bit src; } aop_t;
  aop_t tbl [12];

  initial begin
    int w, t1, c0, n;
    for (int i = 0; i < NREGS; i++) begin mregs[i] = 0; log_valid[i] = 0; log_data[i] = 0; wb_cyc[i] = 0; end
    ram[32'h40] = 32'hDEADBEEF;
    mmem[32'h40] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst iss_ready", {31'd0, iss_ready}, 32'd1);
    check("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst dmem_addr", dmem_addr, 32'd0);
    check("rst dmem_wdata", dmem_wdata, 32'd0);
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    @(negedge clk);

    // Dependent ALU pair
    alu_op(3'd0, 1, 0, 0, 32'd5, 1);
    t1 = last_acc;
    alu_op(3'd0, 2, 1, 0, 32'd7, 1);
    drain();
    check("x1 value", log_data[1], 32'd5);
    check("x2 value", log_data[2], 32'd12);
    check("x1 wb latency", wb_cyc[1] - t1, 32'd2);
    check("x1->x2 wb gap", wb_cyc[2] - wb_cyc[1], GAP1);

    // Load with 3-cycle-late ack, then dependent use
    lat = 4;
    issue(3'd0, 3, 0, 0, 32'h40, 1, 1, 0, 1, 1, w);
    alu_op(3'd0, 4, 3, 0, 32'd1, 1);
    issue(3'd0, 7, 0, 0, 32'd3, 1, 0, 0, 1, 1, w);
    check("load stall cycles", w, WAIT2);
    drain();
    check("load req cycles", last_req_len, 32'd4);
    check("x3 value", log_data[3], 32'hDEADBEEF);
    check("x4 value", log_data[4], 32'hDEADBEF0);

    // Store, same-cycle ack, then read back
    lat = 1;
    c0 = wb_count;
    issue(3'd0, 0, 0, 2, 32'h10, 1, 0, 1, 0, 1, w);
    drain();
    check("store no wb", wb_count - c0, 32'd0);
    check("store req cycles", last_req_len, 32'd1);
    check("store we", {31'd0, last_we}, 32'd1);
    check("store wdata", last_wdata, 32'd12);
    issue(3'd0, 8, 0, 0, 32'h10, 1, 1, 1, 1, 1, w);
    drain();
    check("x8 reload", log_data[8], 32'd12);

    // Writes to x0 are dropped
    c0 = wb_count;
    alu_op(3'd0, 0, 0, 0, 32'd9, 1);
    alu_op(3'd0, 5, 0, 0, 32'd1, 1);
    drain();
    check("x0 wb suppressed", wb_count - c0, 32'd1);
    check("x5 value", log_data[5], 32'd1);

    // Flush the op sitting in EX
    issue(3'd0, 6, 0, 0, 32'd77, 1, 0, 0, 1, 0, w);
    flush = 1;
    @(negedge clk);
    flush = 0;
    issue(3'd0, 9, 0, 0, 32'd2, 1, 0, 0, 1, 1, w);
    check("post-flush accept wait", w, 32'd0);
    drain();
    check("x6 never written", {31'd0, log_valid[6]}, 32'd0);
    check("x9 value", log_data[9], 32'd2);

    // ALU op table with back-to-back dependencies
    tbl[0]  = '{3'd0, 12, 0, 0, 32'hFFFFFFFD, 1};
    tbl[1]  = '{3'd0, 13, 0, 0, 32'h000000F0, 1};
    tbl[2]  = '{3'd1, 14, 12, 13, 32'd0, 0};
    tbl[3]  = '{3'd2, 15, 12, 13, 32'd0, 0};
    tbl[4]  = '{3'd3, 16, 12, 13, 32'd0, 0};
    tbl[5]  = '{3'd4, 17, 12, 13, 32'd0, 0};
    tbl[6]  = '{3'd5, 18, 12, 13, 32'd0, 0};
    tbl[7]  = '{3'd5, 19, 13, 12, 32'd0, 0};
    tbl[8]  = '{3'd6, 20, 13, 0, 32'd36, 1};
    tbl[9]  = '{3'd7, 21, 12, 0, 32'd28, 1};
    tbl[10] = '{3'd6, 22, 14, 18, 32'd0, 0};
    tbl[11] = '{3'd0, 23, 22, 21, 32'd0, 0};
    foreach (tbl[i]) alu_op(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].src);
    drain();
    check("SUB x14", log_data[14], 32'hFFFFFF0D);
    check("AND x15", log_data[15], 32'h000000F0);
    check("SLT neg<pos", log_data[18], 32'd1);
    check("SLT pos<neg", log_data[19], 32'd0);
    check("SLL imm masked", log_data[20], 32'h00000F00);
    check("SRL x21", log_data[21], 32'h0000000F);
    check("SLL reg x22", log_data[22], 32'hFFFFFE1A);
    check("ADD x23", log_data[23], 32'hFFFFFE29);

    // Reset while a load is waiting for ack
    lat = 1000;
    issue(3'd0, 10, 0, 0, 32'h40, 1, 1, 0, 1, 1, w);
    n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); #1; n++; end
    check("pending load req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    exp_q.delete();
    req_q.delete();
    req_len = 0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 0;
    @(negedge clk);
    #1;
    check("rst drops dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst mid wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst mid wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst mid wb_data", wb_data, 32'd0);
    check("rst mid iss_ready", {31'd0, iss_ready}, 32'd1);
    lat = 1;
    rst = 0;
    @(negedge clk);
    alu_op(3'd0, 11, 1, 0, 32'd0, 1);
    drain();
    check("regfile cleared", log_data[11], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
